// File: rtl/dcache_responder.sv
// Direct-mapped, write-back, write-allocate data cache answering MEM-stage word/byte requests.
// Hits respond in the same cycle; misses optionally write back the dirty victim, then fill the line.
`timescale 1ns/1ps
module dcache_responder #(
    parameter int INDEX_BITS = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [15:0]  mem_address,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [15:0]  mem_wdata,
    input  logic [1:0]   mem_byte_enable,
    output logic [15:0]  mem_rdata,
    output logic         mem_resp,
    output logic [15:0]  pmem_address,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [127:0] pmem_wdata,
    input  logic [127:0] pmem_rdata,
    input  logic         pmem_resp
);
    localparam int SETS     = 1 << INDEX_BITS;
    localparam int TAG_BITS = 12 - INDEX_BITS;

    // Handshake: mem_read/mem_write are level-held until mem_resp; a pmem request
    // (pmem_read or pmem_write) is held with stable address/data until pmem_resp.
    typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_t;

    state_t state, next_state;

    logic [SETS-1:0]     valid;
    logic [SETS-1:0]     dirty;
    logic [TAG_BITS-1:0] tag_arr  [SETS];
    logic [127:0]        data_arr [SETS];
    logic [11:0]         miss_addr;

    logic [INDEX_BITS-1:0] req_index;
    logic [TAG_BITS-1:0]   req_tag;
    logic [2:0]            req_word;
    logic [INDEX_BITS-1:0] miss_index;
    logic [TAG_BITS-1:0]   miss_tag;
    logic                  req;
    logic                  hit;
    logic [127:0]          hit_line;
    logic [15:0]           hit_word;
    logic [15:0]           merged_word;
    logic [127:0]          merged_line;
    logic                  do_write_hit;
    logic                  do_fill;
    logic                  latch_miss;

    assign req_index  = mem_address[3+INDEX_BITS:4];
    assign req_tag    = mem_address[15:4+INDEX_BITS];
    assign req_word   = mem_address[3:1];
    assign miss_index = miss_addr[INDEX_BITS-1:0];
    assign miss_tag   = miss_addr[11:INDEX_BITS];
    assign req        = mem_read | mem_write;
    assign hit        = valid[req_index] && (tag_arr[req_index] == req_tag);

    always_comb begin
        hit_line    = data_arr[req_index];
        hit_word    = hit_line[{req_word, 4'b0000} +: 16];
        merged_word = hit_word;
        if (mem_byte_enable[0]) merged_word[7:0]  = mem_wdata[7:0];
        if (mem_byte_enable[1]) merged_word[15:8] = mem_wdata[15:8];
        merged_line = hit_line;
        merged_line[{req_word, 4'b0000} +: 16] = merged_word;
    end

    always_comb begin
        next_state   = state;
        mem_resp     = 1'b0;
        mem_rdata    = 16'h0000;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = 16'h0000;
        pmem_wdata   = 128'h0;
        do_write_hit = 1'b0;
        do_fill      = 1'b0;
        latch_miss   = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        mem_resp     = 1'b1;
                        mem_rdata    = hit_word;
                        do_write_hit = mem_write;
                    end else begin
                        latch_miss = 1'b1;
                        next_state = (valid[req_index] && dirty[req_index]) ? WRITEBACK : FILL;
                    end
                end
            end
            WRITEBACK: begin
                // Victim shares the latched index; its tag still sits in the array.
                pmem_write   = 1'b1;
                pmem_address = {tag_arr[miss_index], miss_index, 4'b0000};
                pmem_wdata   = data_arr[miss_index];
                if (pmem_resp) next_state = FILL;
            end
            FILL: begin
                pmem_read    = 1'b1;
                pmem_address = {miss_addr, 4'b0000};
                if (pmem_resp) begin
                    do_fill    = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            valid     <= '0;
            dirty     <= '0;
            miss_addr <= 12'h000;
        end else begin
            state <= next_state;
            if (latch_miss) miss_addr <= {req_tag, req_index};
            if (do_write_hit) dirty[req_index] <= 1'b1;
            if (do_fill) begin
                valid[miss_index] <= 1'b1;
                dirty[miss_index] <= 1'b0;
            end
        end
    end

    // Tag and data storage carry no reset; valid bits gate their use.
    always_ff @(posedge clk) begin
        if (do_write_hit) data_arr[req_index] <= merged_line;
        if (do_fill) begin
            data_arr[miss_index] <= pmem_rdata;
            tag_arr[miss_index]  <= miss_tag;
        end
    end
endmodule
